// File: rtl/muxn_rr_arbiter.sv
// Round-robin arbiter that steers one of N valid/ready requesters through a shared N:1 mux
// into a single-entry registered output stage.
module muxn_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] mux_out;
    logic             found;
    logic             slot_free;
    logic             grant;

    // Scan ptr, ptr+1, ... wrapping modulo N; the first asserted in_valid wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && in_valid[i] && ((32'(ptr_q) + k) % N) == i) begin
                    found     = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

    // Shared N:1 data mux driven by the grant index.
    always_comb begin
        mux_out = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                mux_out = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign slot_free = (state_q == StEmpty) | out_ready;
    assign grant     = RESETN & found & slot_free;
    assign ptr_d     = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = grant && (grant_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else if (grant) begin
            state_q <= StFull;
            ptr_q   <= ptr_d;
            sel_q   <= grant_idx;
            data_q  <= mux_out;
        end else if (out_ready) begin
            state_q <= StEmpty;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
